ex2_stage: RTL and testbench

Second execute stage of the dual-issue pipe. It sits directly downstream of EX1 and upstream of WB, and holds the EX1→EX2 pipeline register. It finishes multiplication, waits for and aligns dcache load data, and selects the CSR and divider results. It drives the ex1_ex2_* forwarding bus back into EX1, and hands a bundle to WB with a valid/allowin handshake.

---
 rtl/ex2_stage_pkg.sv | 52 +++++
 rtl/ex2_load_align.sv | 32 +++
 rtl/ex2_stage.sv | 204 ++++++++++++++++++++
 tb/tb_ex2_stage.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex2_stage_pkg.sv
// Shared encodings for the EX2 stage: result-source kinds, load-type layout,
// FSM states and the default exception-code width.
package ex2_stage_pkg;

    localparam int unsigned EX2_EXC_W = 7;

    typedef enum logic [2:0] {
        KIND_ALU    = 3'd0,
        KIND_MUL_LO = 3'd1,
        KIND_MUL_HI = 3'd2,
        KIND_LOAD   = 3'd3,
        KIND_CSR    = 3'd4,
        KIND_DIV_Q  = 3'd5,
        KIND_DIV_R  = 3'd6,
        KIND_NONE   = 3'd7
    } kind_e;

    // ld_type[1:0] is the access size, ld_type[2] selects zero-extension
    localparam int unsigned LD_ZEXT_BIT = 2;
    localparam logic [1:0]  LD_SIZE_B   = 2'd0;
    localparam logic [1:0]  LD_SIZE_H   = 2'd1;
    localparam logic [1:0]  LD_SIZE_W   = 2'd2;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        WAIT_MEM = 2'd1,
        DONE     = 2'd2
    } state_e;

    typedef struct packed {
        logic [31:0] pc0;
        logic [31:0] pc1;
        logic [4:0]  rd0;
        logic [4:0]  rd1;
        logic [31:0] res0;
        logic [31:0] res1;
        logic        rv0;
        logic        rv1;
        kind_e       kind;
        logic [2:0]  ld_type;
        logic [1:0]  addr_lo;
        logic [31:0] hh;
        logic [31:0] hl;
        logic [31:0] lh;
        logic [31:0] ll;
        logic [31:0] comp;
        logic [31:0] alt;
        logic        excp;
        logic [31:0] badv;
    } bundle_t;

endpackage

// File: rtl/ex2_load_align.sv
// Extracts the addressed byte/half/word from a dcache read word and extends it.
module ex2_load_align
    import ex2_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  ld_type,
    input  logic [1:0]  addr_lo,
    output logic [31:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        zext;

    always_comb begin
        byte_v = rdata[7:0];
        case (addr_lo)
            2'd1:    byte_v = rdata[15:8];
            2'd2:    byte_v = rdata[23:16];
            2'd3:    byte_v = rdata[31:24];
            default: byte_v = rdata[7:0];
        endcase
        half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        zext   = ld_type[LD_ZEXT_BIT];
        case (ld_type[1:0])
            LD_SIZE_B: data = zext ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
            LD_SIZE_H: data = zext ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
            default:   data = rdata;
        endcase
    end

endmodule

// File: rtl/ex2_stage.sv
// EX2 pipeline stage: EX1->EX2 register, multiply finish, load wait/align, WB hand-off.
// Define EX2_MUL_FWD_EN to forward MUL results on the ex1_ex2 bus once DONE.
module ex2_stage
    import ex2_stage_pkg::*;
#(
    parameter int unsigned EXC_W = EX2_EXC_W
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             flush,
    input  logic             ex1_valid,
    output logic             ex2_allowin,
    input  logic [31:0]      ex1_pc0,
    input  logic [31:0]      ex1_pc1,
    input  logic [4:0]       ex1_rd0,
    input  logic [4:0]       ex1_rd1,
    input  logic [31:0]      ex1_res0,
    input  logic [31:0]      ex1_res1,
    input  logic             ex1_res0_valid,
    input  logic             ex1_res1_valid,
    input  logic [2:0]       ex1_kind0,
    input  logic [2:0]       ex1_ld_type,
    input  logic [1:0]       ex1_addr_lo,
    input  logic [31:0]      mul_hh,
    input  logic [31:0]      mul_hl,
    input  logic [31:0]      mul_lh,
    input  logic [31:0]      mul_ll,
    input  logic [31:0]      mul_comp,
    input  logic [31:0]      csr_rd_data,
    input  logic [31:0]      quotient,
    input  logic [31:0]      remainder,
    input  logic             excp_flag_in,
    input  logic [EXC_W-1:0] exception_in,
    input  logic [31:0]      badv_in,
    input  logic             dcache_rready,
    input  logic [31:0]      dcache_rdata,
    input  logic             wb_allowin,
    output logic             wb_valid,
    output logic [31:0]      wb_pc0,
    output logic [31:0]      wb_pc1,
    output logic [4:0]       wb_rd0,
    output logic [4:0]       wb_rd1,
    output logic [31:0]      wb_data0,
    output logic [31:0]      wb_data1,
    output logic             wb_we0,
    output logic             wb_we1,
    output logic [4:0]       ex1_ex2_rd0,
    output logic [4:0]       ex1_ex2_rd1,
    output logic [31:0]      ex1_ex2_data_0,
    output logic [31:0]      ex1_ex2_data_1,
    output logic             ex1_ex2_data_0_valid,
    output logic             ex1_ex2_data_1_valid,
    output logic             excp_flag_out,
    output logic [EXC_W-1:0] exception_out,
    output logic [31:0]      badv_out
);

    state_e           state_q, state_d;
    bundle_t          bun_q, bun_d;
    logic [EXC_W-1:0] exc_q, exc_d;
    logic [31:0]      load_q, load_d;
    logic             drop_q, drop_d;

    logic        capture;
    logic        occupied;
    logic [63:0] mul_p;
    logic [31:0] load_aligned;
    logic [31:0] data0;
    logic        final0;
    logic        mul_final;

    assign ex2_allowin = (state_q == EMPTY) | ((state_q == DONE) & wb_allowin);
    assign capture     = ex1_valid & ex2_allowin & ~flush;
    assign occupied    = (state_q != EMPTY);

    always_comb begin
        state_d = state_q;
        bun_d   = bun_q;
        exc_d   = exc_q;
        load_d  = load_q;
        drop_d  = drop_q;
        if (dcache_rready && drop_q) begin
            drop_d = 1'b0;
        end
        if (flush) begin
            state_d  = EMPTY;
            bun_d.rv0  = 1'b0;
            bun_d.rv1  = 1'b0;
            bun_d.excp = 1'b0;
            // a live response arriving with the flush retires the squashed load itself
            if (state_q == WAIT_MEM && !(dcache_rready && !drop_q)) begin
                drop_d = 1'b1;
            end
        end else if (capture) begin
            bun_d.pc0     = ex1_pc0;
            bun_d.pc1     = ex1_pc1;
            bun_d.rd0     = ex1_rd0;
            bun_d.rd1     = ex1_rd1;
            bun_d.res0    = ex1_res0;
            bun_d.res1    = ex1_res1;
            bun_d.rv0     = ex1_res0_valid;
            bun_d.rv1     = ex1_res1_valid;
            bun_d.kind    = kind_e'(ex1_kind0);
            bun_d.ld_type = ex1_ld_type;
            bun_d.addr_lo = ex1_addr_lo;
            bun_d.hh      = mul_hh;
            bun_d.hl      = mul_hl;
            bun_d.lh      = mul_lh;
            bun_d.ll      = mul_ll;
            bun_d.comp    = mul_comp;
            case (kind_e'(ex1_kind0))
                KIND_CSR:   bun_d.alt = csr_rd_data;
                KIND_DIV_Q: bun_d.alt = quotient;
                KIND_DIV_R: bun_d.alt = remainder;
                default:    bun_d.alt = '0;
            endcase
            bun_d.excp = excp_flag_in;
            bun_d.badv = badv_in;
            exc_d      = exception_in;
            state_d    = (kind_e'(ex1_kind0) == KIND_LOAD && !excp_flag_in) ? WAIT_MEM : DONE;
        end else begin
            case (state_q)
                WAIT_MEM: begin
                    if (dcache_rready && !drop_q) begin
                        load_d  = dcache_rdata;
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (wb_allowin) begin
                        state_d    = EMPTY;
                        bun_d.rv0  = 1'b0;
                        bun_d.rv1  = 1'b0;
                        bun_d.excp = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= EMPTY;
            bun_q   <= '0;
            exc_q   <= '0;
            load_q  <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bun_q   <= bun_d;
            exc_q   <= exc_d;
            load_q  <= load_d;
            drop_q  <= drop_d;
        end
    end

    ex2_load_align u_load_align (
        .rdata   (load_q),
        .ld_type (bun_q.ld_type),
        .addr_lo (bun_q.addr_lo),
        .data    (load_aligned)
    );

`ifdef EX2_MUL_FWD_EN
    assign mul_final = (state_q == DONE);
`else
    assign mul_final = 1'b0;
`endif

    always_comb begin
        mul_p = {bun_q.hh, 32'h0} + {16'h0, bun_q.hl, 16'h0} + {16'h0, bun_q.lh, 16'h0}
              + {32'h0, bun_q.ll} + {bun_q.comp, 32'h0};
        data0  = bun_q.res0;
        final0 = 1'b1;
        case (bun_q.kind)
            KIND_MUL_LO: begin data0 = mul_p[31:0];  final0 = mul_final; end
            KIND_MUL_HI: begin data0 = mul_p[63:32]; final0 = mul_final; end
            KIND_LOAD:   begin data0 = load_aligned; final0 = (state_q == DONE); end
            KIND_CSR, KIND_DIV_Q, KIND_DIV_R: data0 = bun_q.alt;
            default: ;
        endcase
    end

    assign wb_valid       = (state_q == DONE);
    assign wb_pc0         = bun_q.pc0;
    assign wb_pc1         = bun_q.pc1;
    assign wb_rd0         = bun_q.rd0;
    assign wb_rd1         = bun_q.rd1;
    assign wb_data0       = data0;
    assign wb_data1       = bun_q.res1;
    assign wb_we0         = occupied & bun_q.rv0 & (bun_q.rd0 != 5'd0) & ~bun_q.excp;
    assign wb_we1         = occupied & bun_q.rv1 & (bun_q.rd1 != 5'd0) & ~bun_q.excp;
    assign ex1_ex2_rd0    = occupied ? bun_q.rd0 : 5'd0;
    assign ex1_ex2_rd1    = occupied ? bun_q.rd1 : 5'd0;
    assign ex1_ex2_data_0 = data0;
    assign ex1_ex2_data_1 = bun_q.res1;
    assign ex1_ex2_data_0_valid = wb_we0 & final0;
    assign ex1_ex2_data_1_valid = wb_we1;
    assign excp_flag_out  = bun_q.excp;
    assign exception_out  = exc_q;
    assign badv_out       = bun_q.badv;

endmodule

// File: tb/tb_ex2_stage.sv
// Randomized self-checking bench for ex2_stage against a behavioural model.
module tb_ex2_stage;

    localparam int unsigned EXC_W = 7;
    localparam logic [2:0] K_ALU = 3'd0, K_MUL_LO = 3'd1, K_MUL_HI = 3'd2, K_LOAD = 3'd3;
    localparam logic [2:0] K_CSR = 3'd4, K_DIV_Q = 3'd5, K_DIV_R = 3'd6;
`ifdef EX2_MUL_FWD_EN
    localparam logic MUL_FWD = 1'b1;
`else
    localparam logic MUL_FWD = 1'b0;
`endif

    logic aclk = 1'b0;
    logic aresetn = 1'b0, flush = 1'b0, ex1_valid = 1'b0;
    logic [31:0] ex1_pc0 = '0, ex1_pc1 = '0, ex1_res0 = '0, ex1_res1 = '0;
    logic [4:0]  ex1_rd0 = '0, ex1_rd1 = '0;
    logic ex1_res0_valid = 1'b1, ex1_res1_valid = 1'b1;
    logic [2:0]  ex1_kind0 = '0, ex1_ld_type = '0;
    logic [1:0]  ex1_addr_lo = '0;
    logic [31:0] mul_hh = '0, mul_hl = '0, mul_lh = '0, mul_ll = '0, mul_comp = '0;
    logic [31:0] csr_rd_data = '0, quotient = '0, remainder = '0, badv_in = '0, dcache_rdata = '0;
    logic excp_flag_in = 1'b0, dcache_rready = 1'b0, wb_allowin = 1'b1;
    logic [EXC_W-1:0] exception_in = '0;

    logic ex2_allowin, wb_valid, wb_we0, wb_we1, dv0, dv1, excp_flag_out;
    logic [31:0] wb_pc0, wb_pc1, wb_data0, wb_data1, fwd_d0, fwd_d1, badv_out;
    logic [4:0]  wb_rd0, wb_rd1, fwd_rd0, fwd_rd1;
    logic [EXC_W-1:0] exception_out;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_pc0;

    always #5 aclk = ~aclk;

    ex2_stage #(.EXC_W(EXC_W)) dut (
        .aclk(aclk), .aresetn(aresetn), .flush(flush), .ex1_valid(ex1_valid),
        .ex2_allowin(ex2_allowin), .ex1_pc0(ex1_pc0), .ex1_pc1(ex1_pc1),
        .ex1_rd0(ex1_rd0), .ex1_rd1(ex1_rd1), .ex1_res0(ex1_res0), .ex1_res1(ex1_res1),
        .ex1_res0_valid(ex1_res0_valid), .ex1_res1_valid(ex1_res1_valid),
        .ex1_kind0(ex1_kind0), .ex1_ld_type(ex1_ld_type), .ex1_addr_lo(ex1_addr_lo),
        .mul_hh(mul_hh), .mul_hl(mul_hl), .mul_lh(mul_lh), .mul_ll(mul_ll), .mul_comp(mul_comp),
        .csr_rd_data(csr_rd_data), .quotient(quotient), .remainder(remainder),
        .excp_flag_in(excp_flag_in), .exception_in(exception_in), .badv_in(badv_in),
        .dcache_rready(dcache_rready), .dcache_rdata(dcache_rdata), .wb_allowin(wb_allowin),
        .wb_valid(wb_valid), .wb_pc0(wb_pc0), .wb_pc1(wb_pc1), .wb_rd0(wb_rd0), .wb_rd1(wb_rd1),
        .wb_data0(wb_data0), .wb_data1(wb_data1), .wb_we0(wb_we0), .wb_we1(wb_we1),
        .ex1_ex2_rd0(fwd_rd0), .ex1_ex2_rd1(fwd_rd1), .ex1_ex2_data_0(fwd_d0),
        .ex1_ex2_data_1(fwd_d1), .ex1_ex2_data_0_valid(dv0), .ex1_ex2_data_1_valid(dv1),
        .excp_flag_out(excp_flag_out), .exception_out(exception_out), .badv_out(badv_out)
    );

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] t, input logic [1:0] a);
        logic [31:0] v;
        if (t[1:0] == 2'd0) begin
            v = (w >> (8 * a)) & 32'hFF;
            if (!t[2] && v[7]) v = v | 32'hFFFF_FF00;
        end else if (t[1:0] == 2'd1) begin
            v = (w >> (16 * a[1])) & 32'hFFFF;
            if (!t[2] && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic hi);
        longint sa, sb, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p = sa * sb;
        return hi ? p[63:32] : p[31:0];
    endfunction

    // Splits a signed 32x32 product into 16-bit partial products plus sign correction
    task automatic set_mul(input logic [31:0] a, input logic [31:0] b);
        mul_hh = {16'h0, a[31:16]} * {16'h0, b[31:16]};
        mul_hl = {16'h0, a[31:16]} * {16'h0, b[15:0]};
        mul_lh = {16'h0, a[15:0]} * {16'h0, b[31:16]};
        mul_ll = {16'h0, a[15:0]} * {16'h0, b[15:0]};
        mul_comp = (a[31] ? -b : 32'h0) + (b[31] ? -a : 32'h0);
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic drive(input logic [2:0] kind, input logic [4:0] rd0, input logic [4:0] rd1,
                         input logic [31:0] r0, input logic [31:0] r1);
        ex1_valid = 1'b1;
        ex1_kind0 = kind;
        ex1_rd0 = rd0;
        ex1_rd1 = rd1;
        ex1_res0 = r0;
        ex1_res1 = r1;
        ex1_pc0 = $urandom & 32'hFFFF_FFFC;
        ex1_pc1 = ex1_pc0 + 32'd4;
        exp_pc0 = ex1_pc0;
    endtask

    task automatic present(input logic [2:0] kind, input logic [4:0] rd0, input logic [4:0] rd1,
                           input logic [31:0] r0, input logic [31:0] r1);
        drive(kind, rd0, rd1, r0, r1);
        tick();
        ex1_valid = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        tick();
        tick();
        checks++;
        if ({wb_valid, wb_we0, wb_we1, dv0, dv1, excp_flag_out, fwd_rd0, fwd_rd1} !== 16'h0) begin
            errors++;
            $display("FAIL reset_ctrl got %h exp 0", {wb_valid, wb_we0, wb_we1, dv0, dv1, excp_flag_out, fwd_rd0, fwd_rd1});
        end
        checks++;
        if ({wb_data0, wb_pc0, badv_out} !== 96'h0) begin
            errors++;
            $display("FAIL reset_data got %h/%h/%h exp 0", wb_data0, wb_pc0, badv_out);
        end
        aresetn = 1'b1;
        tick();
        checks++;
        if (ex2_allowin !== 1'b1) begin
            errors++;
            $display("FAIL reset_allowin got %b exp 1", ex2_allowin);
        end
    endtask

    task automatic test_alu();
        logic [4:0] r0, r1;
        logic [31:0] d0, d1;
        logic v0, v1;
        wb_allowin = 1'b1;
        present(K_ALU, 5'd3, 5'd4, 32'd5, 32'd7);
        checks++;
        if ({wb_valid, wb_data0, wb_data1, dv0, dv1, ex2_allowin, fwd_rd0} !== {1'b1, 32'd5, 32'd7, 3'b111, 5'd3}) begin
            errors++;
            $display("FAIL alu_pair got v%b %h %h dv%b%b a%b rd%0d exp v1 5 7 dv11 a1 rd3",
                     wb_valid, wb_data0, wb_data1, dv0, dv1, ex2_allowin, fwd_rd0);
        end
        tick();
        checks++;
        if ({wb_valid, fwd_rd0, dv0} !== 7'h0) begin
            errors++;
            $display("FAIL alu_drain got v%b rd%0d dv%b exp 0", wb_valid, fwd_rd0, dv0);
        end
        for (int n = 0; n < 8; n++) begin
            r0 = 5'($urandom_range(3)); r1 = 5'($urandom);
            d0 = $urandom; d1 = $urandom;
            v0 = 1'($urandom); v1 = 1'($urandom);
            ex1_res0_valid = v0; ex1_res1_valid = v1;
            present(K_ALU, r0, r1, d0, d1);
            checks++;
            if ({wb_data0, wb_data1, wb_pc0, wb_we0, wb_we1, dv0, dv1} !==
                {d0, d1, exp_pc0, v0 && r0 != 0, v1 && r1 != 0, v0 && r0 != 0, v1 && r1 != 0}) begin
                errors++;
                $display("FAIL alu_rand got %h %h pc%h we%b%b dv%b%b exp %h %h pc%h rd%0d/%0d v%b%b",
                         wb_data0, wb_data1, wb_pc0, wb_we0, wb_we1, dv0, dv1, d0, d1, exp_pc0, r0, r1, v0, v1);
            end
            tick();
        end
        ex1_res0_valid = 1'b1; ex1_res1_valid = 1'b1;
    endtask

    task automatic run_load(input logic [2:0] t, input logic [1:0] a, input logic [31:0] w, input int unsigned d);
        ex1_ld_type = t; ex1_addr_lo = a;
        present(K_LOAD, 5'd6, 5'd0, 32'h0, 32'h0);
        for (int unsigned c = 0; c < d; c++) begin
            checks++;
            if ({wb_valid, dv0, ex2_allowin, fwd_rd0} !== {3'b000, 5'd6}) begin
                errors++;
                $display("FAIL load_wait got v%b dv%b a%b rd%0d exp 0 0 0 6", wb_valid, dv0, ex2_allowin, fwd_rd0);
            end
            tick();
        end
        dcache_rready = 1'b1; dcache_rdata = w;
        tick();
        dcache_rready = 1'b0;
        checks++;
        if ({wb_valid, dv0, wb_data0} !== {2'b11, ref_load(w, t, a)}) begin
            errors++;
            $display("FAIL load_data got v%b dv%b %h exp %h (t%0d a%0d w%h)",
                     wb_valid, dv0, wb_data0, ref_load(w, t, a), t, a, w);
        end
    endtask

    task automatic test_load();
        wb_allowin = 1'b1;
        run_load(3'b000, 2'd2, 32'h00AB1234, 3);
        tick();
        run_load(3'b100, 2'd2, 32'h00AB1234, 3);
        tick();
        for (int n = 0; n < 8; n++) begin
            run_load({1'($urandom), 2'($urandom_range(2))}, 2'($urandom), $urandom, $urandom_range(3));
            tick();
        end
        // response while holding in DONE must be ignored
        wb_allowin = 1'b0;
        run_load(3'b010, 2'd0, 32'hCAFE_F00D, 1);
        dcache_rready = 1'b1; dcache_rdata = 32'h1111_2222;
        tick();
        dcache_rready = 1'b0;
        checks++;
        if ({wb_valid, wb_data0} !== {1'b1, 32'hCAFE_F00D}) begin
            errors++;
            $display("FAIL load_done_ignore got v%b %h exp 1 cafef00d", wb_valid, wb_data0);
        end
        wb_allowin = 1'b1;
        tick();
    endtask

    task automatic test_mul();
        logic [31:0] a, b;
        logic hi;
        wb_allowin = 1'b1;
        for (int n = 0; n < 10; n++) begin
            if (n < 2) begin a = 32'hFFFF_FFFF; b = 32'd2; hi = (n == 0); end
            else begin a = $urandom; b = $urandom; hi = 1'($urandom); end
            set_mul(a, b);
            present(hi ? K_MUL_HI : K_MUL_LO, 5'd9, 5'd0, 32'h0, 32'h0);
            checks++;
            if ({wb_valid, wb_data0, wb_we0, dv0} !== {1'b1, ref_mul(a, b, hi), 1'b1, MUL_FWD}) begin
                errors++;
                $display("FAIL mul got v%b %h we%b dv%b exp %h dv%b (a%h b%h hi%b)",
                         wb_valid, wb_data0, wb_we0, dv0, ref_mul(a, b, hi), MUL_FWD, a, b, hi);
            end
            tick();
        end
    endtask

    task automatic test_csr_div();
        logic [31:0] c, q, r;
        logic [2:0] k;
        wb_allowin = 1'b1;
        for (int n = 0; n < 6; n++) begin
            c = $urandom; q = $urandom; r = $urandom;
            k = 3'(K_CSR + n % 3);
            csr_rd_data = c; quotient = q; remainder = r;
            present(k, 5'd11, 5'd0, 32'h0, 32'h0);
            csr_rd_data = ~c; quotient = ~q; remainder = ~r;
            #1;
            checks++;
            if ({wb_data0, dv0} !== {(k == K_CSR) ? c : (k == K_DIV_Q) ? q : r, 1'b1}) begin
                errors++;
                $display("FAIL csr_div got %h dv%b exp kind%0d c%h q%h r%h", wb_data0, dv0, k, c, q, r);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] pa;
        wb_allowin = 1'b0;
        present(K_ALU, 5'd8, 5'd0, 32'hAAAA_0001, 32'h0);
        pa = exp_pc0;
        drive(K_ALU, 5'd10, 5'd0, 32'hBBBB_0002, 32'h0);
        for (int n = 0; n < 4; n++) begin
            checks++;
            if ({ex2_allowin, wb_valid, wb_data0, wb_pc0} !== {2'b01, 32'hAAAA_0001, pa}) begin
                errors++;
                $display("FAIL stall got a%b v%b %h pc%h exp 0 1 aaaa0001 %h", ex2_allowin, wb_valid, wb_data0, wb_pc0, pa);
            end
            tick();
        end
        wb_allowin = 1'b1;
        #1;
        checks++;
        if (ex2_allowin !== 1'b1) begin
            errors++;
            $display("FAIL release_allowin got %b exp 1", ex2_allowin);
        end
        tick();
        ex1_valid = 1'b0;
        checks++;
        if ({wb_valid, wb_data0, fwd_rd0} !== {1'b1, 32'hBBBB_0002, 5'd10}) begin
            errors++;
            $display("FAIL handoff_capture got v%b %h rd%0d exp 1 bbbb0002 10", wb_valid, wb_data0, fwd_rd0);
        end
        tick();
    endtask

    task automatic test_flush();
        wb_allowin = 1'b1;
        ex1_ld_type = 3'b010; ex1_addr_lo = 2'd0;
        present(K_LOAD, 5'd7, 5'd0, 32'h0, 32'h0);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if ({wb_valid, ex2_allowin, wb_we0, fwd_rd0} !== {3'b010, 5'd0}) begin
            errors++;
            $display("FAIL flush_wait got v%b a%b we%b rd%0d exp 0 1 0 0", wb_valid, ex2_allowin, wb_we0, fwd_rd0);
        end
        present(K_LOAD, 5'd7, 5'd0, 32'h0, 32'h0);
        dcache_rready = 1'b1; dcache_rdata = 32'h0000_DEAD;
        tick();
        dcache_rready = 1'b0;
        checks++;
        if ({wb_valid, dv0} !== 2'b00) begin
            errors++;
            $display("FAIL stale_drop got v%b dv%b exp 0 0", wb_valid, dv0);
        end
        dcache_rready = 1'b1; dcache_rdata = 32'h0000_1234;
        tick();
        dcache_rready = 1'b0;
        checks++;
        if ({wb_valid, wb_data0} !== {1'b1, 32'h0000_1234}) begin
            errors++;
            $display("FAIL after_flush_load got v%b %h exp 1 00001234", wb_valid, wb_data0);
        end
        tick();
        drive(K_ALU, 5'd2, 5'd3, 32'h55, 32'h66);
        flush = 1'b1;
        tick();
        flush = 1'b0; ex1_valid = 1'b0;
        checks++;
        if ({wb_valid, wb_we0, wb_we1} !== 3'b000) begin
            errors++;
            $display("FAIL flush_vs_capture got v%b we%b%b exp 0 00", wb_valid, wb_we0, wb_we1);
        end
        wb_allowin = 1'b0;
        present(K_ALU, 5'd2, 5'd3, 32'h55, 32'h66);
        flush = 1'b1;
        tick();
        flush = 1'b0; wb_allowin = 1'b1;
        checks++;
        if ({wb_valid, wb_we0, wb_we1, dv0, dv1} !== 5'b0) begin
            errors++;
            $display("FAIL flush_done got v%b we%b%b dv%b%b exp 0", wb_valid, wb_we0, wb_we1, dv0, dv1);
        end
    endtask

    task automatic test_exception();
        logic [EXC_W-1:0] e;
        logic [31:0] bv;
        e = EXC_W'($urandom); bv = $urandom;
        wb_allowin = 1'b1;
        excp_flag_in = 1'b1; exception_in = e; badv_in = bv;
        present(K_LOAD, 5'd5, 5'd9, 32'h1, 32'h2);
        excp_flag_in = 1'b0;
        checks++;
        if ({wb_valid, wb_we0, wb_we1, dv0, dv1, excp_flag_out, exception_out, badv_out} !==
            {5'b10000, 1'b1, e, bv}) begin
            errors++;
            $display("FAIL exception got v%b we%b%b dv%b%b x%b %h %h exp 1 00 00 1 %h %h",
                     wb_valid, wb_we0, wb_we1, dv0, dv1, excp_flag_out, exception_out, badv_out, e, bv);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        wb_allowin = 1'b1;
        for (int n = 0; n < 6; n++) begin
            d = $urandom;
            drive(K_ALU, 5'(n + 1), 5'd0, d, 32'h0);
            tick();
            checks++;
            if ({wb_valid, wb_data0, wb_pc0, fwd_rd0} !== {1'b1, d, exp_pc0, 5'(n + 1)}) begin
                errors++;
                $display("FAIL back_to_back got v%b %h pc%h rd%0d exp %h pc%h rd%0d",
                         wb_valid, wb_data0, wb_pc0, fwd_rd0, d, exp_pc0, n + 1);
            end
        end
        ex1_valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_mul();
        test_csr_div();
        test_backpressure();
        test_flush();
        test_exception();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
